// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared types and unit encodings for the issue stage
package issue_pkg;

    localparam int REG_W   = 4;
    localparam int N_UNITS = 4;

    localparam logic [1:0] UNIT_ALU = 2'd3;
    localparam logic [1:0] UNIT_LD  = 2'd2;
    localparam logic [1:0] UNIT_MUL = 2'd1;
    localparam logic [1:0] UNIT_DIV = 2'd0;

    typedef logic [1:0]       unit_sel_t;
    typedef logic [REG_W-1:0] reg_idx_t;

    // Bit order matches the EXE/WB write-allow vector
    function automatic logic [N_UNITS-1:0] unit_onehot(input unit_sel_t u);
        logic [N_UNITS-1:0] v;
        v = '0;
        case (u)
            UNIT_ALU: v[3] = 1'b1;
            UNIT_LD:  v[2] = 1'b1;
            UNIT_MUL: v[1] = 1'b1;
            UNIT_DIV: v[0] = 1'b1;
            default:  v    = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/scoreboard_bits.sv
// rtl/scoreboard_bits.sv - per-register pending flags with set-over-clear priority
module scoreboard_bits #(
    parameter int RW    = 4,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_set,
    input  logic [RW-1:0]    i_set_idx,
    input  logic             i_clr,
    input  logic [RW-1:0]    i_clr_idx,
    output logic [NREGS-1:0] o_pending
);

    logic [NREGS-1:0] r_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (i_set && (i_set_idx == RW'(r))) begin
                    r_pending[r] <= 1'b1;
                end else if (i_clr && (i_clr_idx == RW'(r))) begin
                    r_pending[r] <= 1'b0;
                end
            end
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - RAW/WAW hazard check and one-hot dispatch to four units
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int DW    = 32,
    parameter int RW    = REG_W,
    parameter int NREGS = 16,
    parameter int NU    = N_UNITS,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_unit,
    input  logic [RW-1:0]    in_rd,
    input  logic             in_wr_rd,
    input  logic [RW-1:0]    in_rs1,
    input  logic [RW-1:0]    in_rs2,
    input  logic             in_use_rs1,
    input  logic             in_use_rs2,
    input  logic [DW-1:0]    in_op_a,
    input  logic [DW-1:0]    in_op_b,
    input  logic [NU-1:0]    unit_ready,
    output logic [NU-1:0]    issue_valid,
    output logic [RW-1:0]    issue_rd,
    output logic             issue_wr_rd,
    output logic [DW-1:0]    issue_a,
    output logic [DW-1:0]    issue_b,
    input  logic             wb_valid,
    input  logic [RW-1:0]    wb_rd,
    output logic [NREGS-1:0] pending,
    output logic [CW-1:0]    stall_cnt
);

    logic             w_raw;
    logic             w_waw;
    logic             w_accept;
    logic [NREGS-1:0] w_pending;

    logic [NU-1:0]    r_issue_valid;
    logic [RW-1:0]    r_issue_rd;
    logic             r_issue_wr_rd;
    logic [DW-1:0]    r_issue_a;
    logic [DW-1:0]    r_issue_b;
    logic [CW-1:0]    r_stall_cnt;

    // Hazards look only at registered pending: a same-cycle write-back does not bypass
    assign w_raw    = (in_use_rs1 & w_pending[in_rs1]) | (in_use_rs2 & w_pending[in_rs2]);
    assign w_waw    = in_wr_rd & w_pending[in_rd];
    assign in_ready = ~w_raw & ~w_waw & unit_ready[in_unit];
    assign w_accept = in_valid & in_ready;

    scoreboard_bits #(
        .RW    (RW),
        .NREGS (NREGS)
    ) u_scoreboard_bits (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_set     (w_accept & in_wr_rd),
        .i_set_idx (in_rd),
        .i_clr     (wb_valid),
        .i_clr_idx (wb_rd),
        .o_pending (w_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_valid <= '0;
            r_issue_rd    <= '0;
            r_issue_wr_rd <= 1'b0;
            r_issue_a     <= '0;
            r_issue_b     <= '0;
        end else begin
            r_issue_valid <= w_accept ? NU'(unit_onehot(unit_sel_t'(in_unit))) : '0;
            if (w_accept) begin
                r_issue_rd    <= in_rd;
                r_issue_wr_rd <= in_wr_rd;
                r_issue_a     <= in_op_a;
                r_issue_b     <= in_op_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (in_valid && !in_ready && (r_stall_cnt != {CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
        end
    end

    assign issue_valid = r_issue_valid;
    assign issue_rd    = r_issue_rd;
    assign issue_wr_rd = r_issue_wr_rd;
    assign issue_a     = r_issue_a;
    assign issue_b     = r_issue_b;
    assign pending     = w_pending;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue stage that sits between decode and the four execution units (ALU, LD, MUL, DIV), upstream of the EXE/WB result-collection registers.
- Accepts one decoded instruction per cycle and checks RAW/WAW hazards against a per-register pending scoreboard.
- Dispatches the instruction to the selected unit with a one-hot valid (same bit order as the EXE/WB write-allow vector) and clears pending bits when the write-back destination arrives.

Parameters:
- DW, 32, operand/result data width
- RW, 4, register index width
- NREGS, 16, architectural registers tracked (2**RW)
- NU, 4, number of execution units; bit 3=ALU, 2=LD, 1=MUL, 0=DIV
- CW, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  issue accepts this cycle (combinational)
- in_unit  in  2  unit select: 3=ALU, 2=LD, 1=MUL, 0=DIV
- in_rd  in  RW  destination register
- in_wr_rd  in  1  instruction writes in_rd
- in_rs1, in_rs2  in  RW each  source registers
- in_use_rs1, in_use_rs2  in  1 each  source actually read
- in_op_a, in_op_b  in  DW each  operand values from the register file
- unit_ready  in  NU  unit can accept a new instruction
- issue_valid  out  NU  one-hot registered dispatch strobe
- issue_rd  out  RW  destination passed to the unit (becomes the unit's Rd)
- issue_wr_rd  out  1  destination-write flag
- issue_a, issue_b  out  DW each  operands
- wb_valid  in  1  write-back retiring a result this cycle
- wb_rd  in  RW  register being written back
- pending  out  NREGS  scoreboard, bit r set = write to r outstanding
- stall_cnt  out  CW  saturating count of cycles in_valid=1 and in_ready=0

Behaviour:
- Reset (async, rst_n=0): issue_valid=0, issue_rd=0, issue_wr_rd=0, issue_a=issue_b=0, pending=0, stall_cnt=0. Reset mid-dispatch drops the instruction; no recovery.
- Unit index u = in_unit; hazard terms use registered pending only:
  - raw = (in_use_rs1 & pending[in_rs1]) | (in_use_rs2 & pending[in_rs2])
  - waw = in_wr_rd & pending[in_rd]
- in_ready = ~raw & ~waw & unit_ready[u]. No dependence on in_valid.
- Accept = in_valid & in_ready at posedge T. After T:
  - issue_valid = one-hot bit u; issue_rd/issue_wr_rd/issue_a/issue_b hold the captured values.
  - pending[in_rd] set if in_wr_rd.
- Cycle with no accept: issue_valid=0 next cycle; data outputs hold their last values. Latency is 1 cycle, throughput 1 per cycle.
- Write-back: wb_valid at posedge T clears pending[wb_rd] after T.
- No same-cycle bypass. A hazard cleared by wb in cycle T permits in_ready in T+1 at the earliest.
- Simultaneous accept with in_wr_rd and wb_valid, in_rd == wb_rd: set wins, pending stays 1. Cannot occur legally (WAW blocks it); required anyway for robustness.
- wb_valid for a register whose pending bit is 0: no effect, no error.
- in_wr_rd=0: no scoreboard update; issue_wr_rd=0 tells the unit to produce no write-back.
- rs == rd in the same instruction (e.g. R3 = R3 + 1): only the pre-accept pending value matters.
- stall_cnt increments when in_valid & ~in_ready and saturates at 2**CW-1; no wrap.
- No FSM beyond the scoreboard. Each pending bit is a two-state set/clear machine per register.

Decomposition:
- Package issue_pkg holds:
  - unit index constants: UNIT_ALU=3, UNIT_LD=2, UNIT_MUL=1, UNIT_DIV=0
  - typedef unit_sel_t (2 bits)
  - typedef reg_idx_t (RW bits)
- One natural sub-module: scoreboard_bits. Holds the NREGS pending flops with set/clear ports and set-priority.
- Hazard compare, one-hot decode, and the stall counter stay in the top module.

Test Plan:
- Reset then ALU instr rd=5, wr_rd=1, a=0x10, b=0x20, unit_ready=4'b1111 -> next cycle issue_valid=4'b1000, issue_rd=5, issue_a=0x10, issue_b=0x20, pending=0x0020; following cycle issue_valid=0.
- RAW: MUL rd=2 issued, then ALU rs1=2 presented -> in_ready=0 until wb_valid, wb_rd=2 at cycle T; in_ready=1 in T+1; stall_cnt equals the number of blocked cycles.
- WAW: DIV rd=7 pending, LD rd=7 presented -> stalls; after wb_rd=7, LD issues with issue_valid=4'b0100 and pending[7]=1 again.
- Unit busy: unit_ready=4'b1101, MUL instr with no hazards -> in_ready=0; raising unit_ready[1] -> issues next edge with issue_valid=4'b0010.
- Simultaneous set/clear: force accept rd=9 and wb_rd=9 in the same cycle (pending[9] preloaded 0) -> pending[9]=1. Stray wb_rd=4 with pending[4]=0 -> no change.
- Reset mid-operation: pending=0x00FF, assert rst_n=0 between clock edges -> all outputs 0 immediately. Force stall_cnt to saturate at 0xFFFF and hold.
